execute_unit_hs: RTL and testbench
==================================

Name: execute_unit_hs

Overview:
- Parametrised, handshaked successor to the core's single-cycle execute stage.
- Registered ALU, branch compare and memory-request generation, with valid/ready flow control on both sides.
- Adds an iterative multi-cycle multiplier, an arithmetic right shift and a pipeline flush.
- Sits between decode (upstream) and the memory/writeback stage (downstream).

Parameters:
- XLEN, 32: datapath width. Must be a power of two, >= 8.
- ADDR_W, 20: memory address width. ADDR_W <= XLEN.
- MUL_EN, 1: 1 = multiplier present. 0 = the MUL op completes single-cycle with result 0.
- SHAMT_W, $clog2(XLEN): shift-amount width. Derived; do not override.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; discards the held result and aborts any multiply
- in_valid  in  1  upstream operation valid
- in_ready  out  1  upstream may transfer
- alu_op  in  4  operation code (exec_pkg)
- rs1_data  in  XLEN  operand A
- rs2_data  in  XLEN  operand B / store data
- imm  in  XLEN  address offset
- out_valid  out  1  result register valid
- out_ready  in  1  downstream accepts
- alu_result  out  XLEN  registered result
- branch_taken  out  1  registered branch decision
- mem_addr  out  ADDR_W  (rs1_data+imm)[ADDR_W-1:0]
- mem_wdata  out  XLEN  store data
- mem_we  out  1  store request; qualified by out_valid
- mem_re  out  1  load request; qualified by out_valid
- busy  out  1  multiplier iterating

Behaviour:
- Reset (async, rst_n=0): every registered output 0; FSM returns to IDLE. in_ready=1 once reset is released.
- Transfer rules:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_ready = (state==IDLE) & (!out_valid | out_ready), combinational.
  - Output fields hold stable while out_valid & !out_ready.
- Op codes and results:
  - 0 ADD: A+B, mod 2^XLEN.
  - 1 SUB: A-B.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SHL: A<<B[SHAMT_W-1:0].
  - 6 SHR: logical right shift.
  - 7 SLT: signed A<B as 0/1.
  - 8 LOAD: result=A+imm, mem_re=1.
  - 9 STORE: result=A+imm, mem_we=1, mem_wdata=B.
  - A MUL: low XLEN bits of A*B, unsigned.
  - B SRA: arithmetic right shift.
  - C BEQ: branch_taken=(A==B), result=A-B.
  - D BLT: branch_taken=signed A<B, result=SLT value.
  - E, F: result 0, all flags 0, still produces out_valid.
- Flag defaults: branch_taken=0 for all ops except C/D. mem_we/mem_re=0 except ops 9/8. mem_addr is computed for every op.
- Single-cycle ops: accepted in cycle N -> out_valid=1 in cycle N+1. Back-to-back throughput 1/cycle while out_ready=1.
- MUL FSM: IDLE -> BUSY -> DONE -> IDLE.
  - IDLE: on accept of op A with MUL_EN=1, latch A/B, clear accumulator and count, go to BUSY.
  - BUSY: shift-add one multiplier bit per cycle. After XLEN iterations go to DONE. busy=1 and in_ready=0 throughout.
  - DONE: load the output register when (!out_valid | out_ready), then return to IDLE.
  - Latency from accept to out_valid is XLEN+2 cycles (34 for XLEN=32).
- flush=1 (highest priority after reset):
  - out_valid<=0; FSM->IDLE; accumulator discarded.
  - in_ready=0 in the flush cycle; no accept occurs.
  - Data fields keep their values, but mem_we/mem_re clear to 0.
- Simultaneous output transfer and new accept in the same cycle: the register reloads; out_valid stays 1.
- Reset mid-multiply: FSM->IDLE, no output produced.

Decomposition:
- exec_pkg holds:
  - 4-bit op localparams (OP_ADD..OP_BLT).
  - FSM state encoding (IDLE/BUSY/DONE).
- One sub-module, exec_mul_iter: parameter XLEN; ports start, a, b, done, product.
  - It contains the BUSY counter and the shift-add logic.
- The top level owns the handshake, the result register and the FSM sequencing.

Test Plan:
1. Reset, then ADD 0x7FFFFFFF+0x00000001 with out_ready=1 -> out_valid next cycle, alu_result=0x80000000, branch_taken=0.
2. STORE rs1=0x000FFFF0, imm=0x20, rs2=0xDEADBEEF -> mem_addr=0x00010 (20-bit wrap), mem_we=1, mem_wdata=0xDEADBEEF, mem_re=0.
3. SRA 0x80000000 by 4 -> 0xF8000000. SHR gives 0x08000000. BLT A=0xFFFFFFFF, B=1 -> branch_taken=1.
4. MUL 0x00012345 * 0x00000100 -> busy for 32 cycles, in_ready=0 during, out_valid at accept+34, result 0x01234500.
5. Hold out_ready=0 for 5 cycles with two ops queued upstream -> first result stable, in_ready=0. Release -> second op accepted the same cycle, results in order.
6. flush asserted 10 cycles into a MUL -> out_valid stays 0, busy drops next cycle, next ADD completes normally. Also assert rst_n low mid-MUL -> all outputs 0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared op encodings and multiply FSM states for the handshaked execute stage.
package exec_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SHL   = 4'h5;
  localparam logic [3:0] OP_SHR   = 4'h6;
  localparam logic [3:0] OP_SLT   = 4'h7;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_MUL   = 4'hA;
  localparam logic [3:0] OP_SRA   = 4'hB;
  localparam logic [3:0] OP_BEQ   = 4'hC;
  localparam logic [3:0] OP_BLT   = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, XLEN cycles.
module exec_mul_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (abort) begin
      run_d = 1'b0;
    end else if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(XLEN-1)) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

  // High during the final iteration; product is complete after this edge.
  assign done    = run_q & (cnt_q == CNT_W'(XLEN-1));
  assign product = acc_q;

endmodule

// File: rtl/execute_unit_hs.sv
// Handshaked execute stage: registered ALU/branch/memory request, iterative MUL, flush.
module execute_unit_hs
  import exec_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 20,
  parameter int MUL_EN  = 1,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_op,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_result,
  output logic              branch_taken,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              busy
);

  localparam bit HAS_MUL = (MUL_EN != 0);

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   alu_result_q, alu_result_d;
  logic              branch_taken_q, branch_taken_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic [ADDR_W-1:0] mul_addr_q, mul_addr_d;
  logic [XLEN-1:0]   mul_wdata_q, mul_wdata_d;

  logic              accept, is_mul, mul_start, mul_done;
  logic [XLEN-1:0]   mul_product;
  logic [XLEN-1:0]   sum_ai, diff_ab, op_res;
  logic [SHAMT_W-1:0] shamt;
  logic              slt, op_br, op_we, op_re;

  assign in_ready  = (state_q == ST_IDLE) & (!out_valid_q | out_ready) & !flush;
  assign accept    = in_valid & in_ready;
  assign is_mul    = HAS_MUL && (alu_op == OP_MUL);
  assign mul_start = accept & is_mul;

  generate
    if (HAS_MUL) begin : g_mul
      exec_mul_iter #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .abort   (flush),
        .a       (rs1_data),
        .b       (rs2_data),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  // Single-cycle result and flags for the op currently presented upstream.
  always_comb begin
    sum_ai  = rs1_data + imm;
    diff_ab = rs1_data - rs2_data;
    shamt   = rs2_data[SHAMT_W-1:0];
    slt     = $signed(rs1_data) < $signed(rs2_data);
    op_res  = '0;
    op_br   = 1'b0;
    op_we   = 1'b0;
    op_re   = 1'b0;
    case (alu_op)
      OP_ADD:   op_res = rs1_data + rs2_data;
      OP_SUB:   op_res = diff_ab;
      OP_AND:   op_res = rs1_data & rs2_data;
      OP_OR:    op_res = rs1_data | rs2_data;
      OP_XOR:   op_res = rs1_data ^ rs2_data;
      OP_SHL:   op_res = rs1_data << shamt;
      OP_SHR:   op_res = rs1_data >> shamt;
      OP_SLT:   op_res = {{(XLEN-1){1'b0}}, slt};
      OP_LOAD:  begin op_res = sum_ai; op_re = 1'b1; end
      OP_STORE: begin op_res = sum_ai; op_we = 1'b1; end
      OP_SRA:   op_res = $signed(rs1_data) >>> shamt;
      OP_BEQ:   begin op_res = diff_ab; op_br = (rs1_data == rs2_data); end
      OP_BLT:   begin op_res = {{(XLEN-1){1'b0}}, slt}; op_br = slt; end
      default:  op_res = '0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    out_valid_d    = out_valid_q;
    alu_result_d   = alu_result_q;
    branch_taken_d = branch_taken_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_we_d       = mem_we_q;
    mem_re_d       = mem_re_q;
    mul_addr_d     = mul_addr_q;
    mul_wdata_d    = mul_wdata_q;
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      mem_we_d    = 1'b0;
      mem_re_d    = 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mul_start) begin
            state_d     = ST_BUSY;
            mul_addr_d  = sum_ai[ADDR_W-1:0];
            mul_wdata_d = rs2_data;
          end else if (accept) begin
            out_valid_d    = 1'b1;
            alu_result_d   = op_res;
            branch_taken_d = op_br;
            mem_addr_d     = sum_ai[ADDR_W-1:0];
            mem_wdata_d    = rs2_data;
            mem_we_d       = op_we;
            mem_re_d       = op_re;
          end
        end
        ST_BUSY: if (mul_done) state_d = ST_DONE;
        ST_DONE: begin
          // Wait for a free output slot before publishing the product.
          if (!out_valid_q || out_ready) begin
            state_d        = ST_IDLE;
            out_valid_d    = 1'b1;
            alu_result_d   = mul_product;
            branch_taken_d = 1'b0;
            mem_addr_d     = mul_addr_q;
            mem_wdata_d    = mul_wdata_q;
            mem_we_d       = 1'b0;
            mem_re_d       = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      out_valid_q    <= 1'b0;
      alu_result_q   <= '0;
      branch_taken_q <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_we_q       <= 1'b0;
      mem_re_q       <= 1'b0;
      mul_addr_q     <= '0;
      mul_wdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      alu_result_q   <= alu_result_d;
      branch_taken_q <= branch_taken_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_we_q       <= mem_we_d;
      mem_re_q       <= mem_re_d;
      mul_addr_q     <= mul_addr_d;
      mul_wdata_q    <= mul_wdata_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign alu_result   = alu_result_q;
  assign branch_taken = branch_taken_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_we       = mem_we_q;
  assign mem_re       = mem_re_q;
  assign busy         = (state_q == ST_BUSY);

endmodule

// File: tb/tb_execute_unit_hs.sv
// Directed bench for execute_unit_hs: ALU ops, handshake stalls, MUL latency, flush, reset.
module tb_execute_unit_hs;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  alu_op;
  logic [31:0] rs1_data, rs2_data, imm, alu_result, mem_wdata;
  logic [19:0] mem_addr;
  logic        branch_taken, mem_we, mem_re, busy;

  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt, rdy_bad, k_out, stray;

  always #5 clk = ~clk;

  execute_unit_hs #(.XLEN(32), .ADDR_W(20), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .branch_taken(branch_taken),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im);
    in_valid = 1'b1; alu_op = op; rs1_data = a; rs2_data = b; imm = im;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 4'h0; rs1_data = '0; rs2_data = '0; imm = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", alu_result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Single-cycle ops, back to back
    issue(OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h0);
    @(negedge clk);
    chk("add_valid", out_valid, 1);
    chk("add_result", alu_result, 32'h80000000);
    chk("add_br", branch_taken, 0);
    issue(OP_STORE, 32'h000FFFF0, 32'hDEADBEEF, 32'h20);
    @(negedge clk);
    chk("st_addr", mem_addr, 32'h00010);
    chk("st_we", mem_we, 1);
    chk("st_re", mem_re, 0);
    chk("st_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_result", alu_result, 32'h00100010);
    issue(OP_SRA, 32'h80000000, 32'h4, 32'h0);
    @(negedge clk);
    chk("sra", alu_result, 32'hF8000000);
    chk("sra_we", mem_we, 0);
    issue(OP_SHR, 32'h80000000, 32'h4, 32'h0);
    @(negedge clk);
    chk("shr", alu_result, 32'h08000000);
    issue(OP_SHL, 32'h1, 32'h21, 32'h0);
    @(negedge clk);
    chk("shl_shamt_mask", alu_result, 32'h2);
    issue(OP_BLT, 32'hFFFFFFFF, 32'h1, 32'h0);
    @(negedge clk);
    chk("blt_br", branch_taken, 1);
    chk("blt_result", alu_result, 32'h1);
    issue(OP_BEQ, 32'h5, 32'h5, 32'h0);
    @(negedge clk);
    chk("beq_br", branch_taken, 1);
    chk("beq_result", alu_result, 32'h0);
    issue(OP_LOAD, 32'h100, 32'h0, 32'h4);
    @(negedge clk);
    chk("ld_re", mem_re, 1);
    chk("ld_result", alu_result, 32'h104);
    chk("ld_br", branch_taken, 0);
    issue(4'hE, 32'h1234, 32'h5678, 32'h0);
    @(negedge clk);
    chk("opE_valid", out_valid, 1);
    chk("opE_result", alu_result, 32'h0);
    chk("opE_re", mem_re, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_valid", out_valid, 0);

    // Multiply: latency and busy window
    issue(OP_MUL, 32'h00012345, 32'h00000100, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    busy_cnt = 0; rdy_bad = 0; k_out = 0;
    for (int k = 1; k <= 60 && k_out == 0; k++) begin
      if (busy) begin
        busy_cnt++;
        if (in_ready) rdy_bad++;
      end
      if (out_valid) k_out = k;
      else @(negedge clk);
    end
    chk("mul_busy_cycles", busy_cnt, 32);
    chk("mul_in_ready_busy", rdy_bad, 0);
    chk("mul_latency", k_out, 34);
    chk("mul_result", alu_result, 32'h01234500);
    chk("mul_we", mem_we, 0);

    // Output transfer and new accept in the same cycle, then stall
    issue(OP_ADD, 32'h1, 32'h2, 32'h0);
    @(negedge clk);
    chk("reload_valid", out_valid, 1);
    chk("reload_result", alu_result, 32'h3);
    out_ready = 1'b0;
    issue(OP_SUB, 32'd10, 32'd3, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_result", alu_result, 32'h3);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", in_ready, 1);
    @(negedge clk);
    chk("second_valid", out_valid, 1);
    chk("second_result", alu_result, 32'h7);
    in_valid = 1'b0;
    @(negedge clk);
    chk("second_drain", out_valid, 0);

    // Flush a held store: data kept, request flags cleared
    issue(OP_STORE, 32'h100, 32'hCAFE, 32'h4);
    out_ready = 1'b0;
    @(negedge clk);
    chk("hold_st_we", mem_we, 1);
    in_valid = 1'b0;
    flush = 1'b1;
    #1 chk("flush_in_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b1;
    chk("flush_valid", out_valid, 0);
    chk("flush_we", mem_we, 0);
    chk("flush_keep_result", alu_result, 32'h104);

    // Flush ten cycles into a multiply
    issue(OP_MUL, 32'h3, 32'h5, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("fmul_busy", busy, 1);
    flush = 1'b1;
    issue(OP_ADD, 32'h4, 32'h6, 32'h0);
    #1 chk("fmul_in_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("fmul_busy_drop", busy, 0);
    chk("fmul_valid", out_valid, 0);
    @(negedge clk);
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_result", alu_result, 32'd10);
    in_valid = 1'b0;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    chk("fmul_no_stray", stray, 0);

    // Reset in the middle of a multiply
    issue(OP_MUL, 32'h7, 32'h9, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rmul_valid", out_valid, 0);
    chk("rmul_busy", busy, 0);
    chk("rmul_result", alu_result, 0);
    chk("rmul_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid || busy) stray++;
    end
    chk("rmul_no_stray", stray, 0);
    issue(OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0);
    @(negedge clk);
    chk("wrap_valid", out_valid, 1);
    chk("wrap_result", alu_result, 32'h0);
    in_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
